// File: rtl/fm_voice_seq.sv
// fm_voice_seq: sample tick, time-multiplexed operator sequencer, stereo
// accumulate/saturate mixer, key-on/restart bookkeeping and overrun flag.
// Optional build macro FMSEQ_PEAK_EN adds peak_l/peak_r meters and peak_clr.
module fm_voice_seq #(
    parameter  int NUM_OPS    = 64,
    parameter  int OPS_PER_CH = 2,
    parameter  int SAMPLE_DIV = 506,
    parameter  int RES_W      = 13,
    parameter  int OUT_W      = 16,
    localparam int NUM_CH     = NUM_OPS / OPS_PER_CH,
    localparam int OP_W       = $clog2(NUM_OPS),
    localparam int ACC_W      = RES_W + OP_W,
    localparam int CNT_W      = $clog2(SAMPLE_DIV)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              kon_wr,
    input  logic [NUM_CH-1:0] kon_wrdata,
    output logic              bus_wait,
    output logic [NUM_CH-1:0] kon,
    output logic [NUM_CH-1:0] restart,
    output logic [OP_W-1:0]   op_sel,
    output logic              op_next,
    output logic              op_first,
    input  logic [RES_W-1:0]  op_result,
    input  logic              op_sum,
    input  logic              op_pan_l,
    input  logic              op_pan_r,
    input  logic [1:0]        op_vol,
    output logic [OUT_W-1:0]  audio_l,
    output logic [OUT_W-1:0]  audio_r,
    output logic              audio_valid,
    output logic              overrun,
`ifdef FMSEQ_PEAK_EN
    input  logic              peak_clr,
    output logic [OUT_W-2:0]  peak_l,
    output logic [OUT_W-2:0]  peak_r,
`endif
    input  logic              overrun_clr
);

    typedef enum logic [1:0] {IDLE, START, PROCESS, NEXT} state_t;

    // Saturation bounds expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     tick_q, tick_d;
    logic [OP_W-1:0]          op_sel_q, op_sel_d;
    logic                     op_next_q, op_next_d;
    logic                     op_first_q, op_first_d;
    logic signed [ACC_W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [ACC_W-1:0]  term_ext, term;
    logic [NUM_CH-1:0]        kon_q, kon_d, restart_q, restart_d;
    logic [OUT_W-1:0]         audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic                     audio_valid_q, audio_valid_d;
    logic                     overrun_q, overrun_d;
    logic                     kon_accept, end_of_pass;

    function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if (a < SAT_MIN)
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return a[OUT_W-1:0];
    endfunction

    assign bus_wait    = kon_wr && (state_q != IDLE);
    assign kon_accept  = kon_wr && !bus_wait;
    assign end_of_pass = (state_q == NEXT) && (op_sel_q == OP_W'(NUM_OPS - 1));

    // Sample-rate divider; tick is a registered one-cycle pulse on wrap
    always_comb begin
        tick_d = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
    end

    // Sequencer, mixer, key-on and overrun next-state logic
    always_comb begin
        state_d       = state_q;
        op_sel_d      = op_sel_q;
        op_first_d    = op_first_q;
        acc_l_d       = acc_l_q;
        acc_r_d       = acc_r_q;
        kon_d         = kon_q;
        restart_d     = restart_q;
        audio_l_d     = audio_l_q;
        audio_r_d     = audio_r_q;
        audio_valid_d = 1'b0;
        overrun_d     = overrun_q;
        term_ext      = ACC_W'($signed(op_result));
        term          = term_ext >>> op_vol;

        case (state_q)
            IDLE: begin
                if (tick_q)
                    state_d = START;
            end
            START: begin
                op_sel_d = '0;
                state_d  = PROCESS;
            end
            PROCESS: begin
                // During the initialisation pass results are not trusted
                if (!op_first_q && op_sum) begin
                    if (op_pan_l)
                        acc_l_d = acc_l_q + term;
                    if (op_pan_r)
                        acc_r_d = acc_r_q + term;
                end
                state_d = NEXT;
            end
            NEXT: begin
                if (!end_of_pass) begin
                    op_sel_d = op_sel_q + OP_W'(1);
                    state_d  = PROCESS;
                end else begin
                    audio_l_d     = sat(acc_l_q);
                    audio_r_d     = sat(acc_r_q);
                    acc_l_d       = '0;
                    acc_r_d       = '0;
                    restart_d     = '0;
                    op_first_d    = 1'b0;
                    audio_valid_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Writes are only accepted in IDLE, so never collide with end-of-pass
        if (kon_accept) begin
            kon_d     = kon_wrdata;
            restart_d = restart_q | (~kon_q & kon_wrdata);
        end

        // A dropped tick takes priority over the clear request
        if (tick_q && (state_q != IDLE))
            overrun_d = 1'b1;
        else if (overrun_clr)
            overrun_d = 1'b0;
    end

    assign op_next_d = (state_d == NEXT);

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tick_q        <= 1'b0;
            op_sel_q      <= '0;
            op_next_q     <= 1'b0;
            op_first_q    <= 1'b1;
            acc_l_q       <= '0;
            acc_r_q       <= '0;
            kon_q         <= '0;
            restart_q     <= '0;
            audio_l_q     <= '0;
            audio_r_q     <= '0;
            audio_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            op_sel_q      <= op_sel_d;
            op_next_q     <= op_next_d;
            op_first_q    <= op_first_d;
            acc_l_q       <= acc_l_d;
            acc_r_q       <= acc_r_d;
            kon_q         <= kon_d;
            restart_q     <= restart_d;
            audio_l_q     <= audio_l_d;
            audio_r_q     <= audio_r_d;
            audio_valid_q <= audio_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign kon         = kon_q;
    assign restart     = restart_q;
    assign op_sel      = op_sel_q;
    assign op_next     = op_next_q;
    assign op_first    = op_first_q;
    assign audio_l     = audio_l_q;
    assign audio_r     = audio_r_q;
    assign audio_valid = audio_valid_q;
    assign overrun     = overrun_q;

`ifdef FMSEQ_PEAK_EN
    logic [OUT_W-2:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
    logic [OUT_W-2:0] mag_l, mag_r;

    // Magnitude of a saturated sample; the most negative code reads as full scale
    function automatic logic [OUT_W-2:0] mag(input logic [OUT_W-1:0] s);
        logic [OUT_W-1:0] n;
        n = -s;
        if (!s[OUT_W-1])
            return s[OUT_W-2:0];
        else if (s == {1'b1, {(OUT_W-1){1'b0}}})
            return '1;
        else
            return n[OUT_W-2:0];
    endfunction

    // Peak hold; a clear coinciding with an update restarts from that sample
    always_comb begin
        mag_l    = mag(audio_l_d);
        mag_r    = mag(audio_r_d);
        peak_l_d = peak_l_q;
        peak_r_d = peak_r_q;
        if (end_of_pass) begin
            peak_l_d = (peak_clr || mag_l > peak_l_q) ? mag_l : peak_l_q;
            peak_r_d = (peak_clr || mag_r > peak_r_q) ? mag_r : peak_r_q;
        end else if (peak_clr) begin
            peak_l_d = '0;
            peak_r_d = '0;
        end
    end

    // Peak registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign peak_l = peak_l_q;
    assign peak_r = peak_r_q;
`endif

endmodule

// File: tb/tb_fm_voice_seq.sv
// tb_fm_voice_seq: directed checks on three fm_voice_seq instances
// (8 ops / 32-cycle sample, 64 ops for saturation, 8 ops with a too-short
// sample period to provoke overrun).
module tb_fm_voice_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- instance A: NUM_OPS=8, SAMPLE_DIV=32 ----------------
    logic        a_rst_n, a_kon_wr, a_bus_wait, a_op_next, a_op_first;
    logic [3:0]  a_kon_wrdata, a_kon, a_restart;
    logic [2:0]  a_op_sel;
    logic [12:0] a_op_result;
    logic        a_op_sum, a_pan_l, a_pan_r, a_valid, a_overrun;
    logic [1:0]  a_vol;
    logic [15:0] a_audio_l, a_audio_r;
`ifdef FMSEQ_PEAK_EN
    logic [14:0] a_peak_l, a_peak_r, s_peak_l, s_peak_r, o_peak_l, o_peak_r;
`endif

    fm_voice_seq #(.NUM_OPS(8), .OPS_PER_CH(2), .SAMPLE_DIV(32), .RES_W(13), .OUT_W(16)) u_a (
        .clk(clk), .reset_n(a_rst_n), .kon_wr(a_kon_wr), .kon_wrdata(a_kon_wrdata),
        .bus_wait(a_bus_wait), .kon(a_kon), .restart(a_restart), .op_sel(a_op_sel),
        .op_next(a_op_next), .op_first(a_op_first), .op_result(a_op_result),
        .op_sum(a_op_sum), .op_pan_l(a_pan_l), .op_pan_r(a_pan_r), .op_vol(a_vol),
        .audio_l(a_audio_l), .audio_r(a_audio_r), .audio_valid(a_valid),
        .overrun(a_overrun),
`ifdef FMSEQ_PEAK_EN
        .peak_clr(1'b0), .peak_l(a_peak_l), .peak_r(a_peak_r),
`endif
        .overrun_clr(1'b0));

    // ---------------- instance S: NUM_OPS=64, SAMPLE_DIV=140 ----------------
    logic        s_rst_n, s_bus_wait, s_op_next, s_op_first, s_valid, s_overrun;
    logic [31:0] s_kon, s_restart;
    logic [5:0]  s_op_sel;
    logic [12:0] s_op_result;
    logic [15:0] s_audio_l, s_audio_r;

    fm_voice_seq #(.NUM_OPS(64), .OPS_PER_CH(2), .SAMPLE_DIV(140), .RES_W(13), .OUT_W(16)) u_s (
        .clk(clk), .reset_n(s_rst_n), .kon_wr(1'b0), .kon_wrdata(32'h0),
        .bus_wait(s_bus_wait), .kon(s_kon), .restart(s_restart), .op_sel(s_op_sel),
        .op_next(s_op_next), .op_first(s_op_first), .op_result(s_op_result),
        .op_sum(1'b1), .op_pan_l(1'b1), .op_pan_r(1'b1), .op_vol(2'd0),
        .audio_l(s_audio_l), .audio_r(s_audio_r), .audio_valid(s_valid),
        .overrun(s_overrun),
`ifdef FMSEQ_PEAK_EN
        .peak_clr(1'b0), .peak_l(s_peak_l), .peak_r(s_peak_r),
`endif
        .overrun_clr(1'b0));

    // ---------------- instance O: NUM_OPS=8, SAMPLE_DIV=17 ----------------
    logic        o_rst_n, o_clr, o_bus_wait, o_op_next, o_op_first, o_valid, o_overrun;
    logic [3:0]  o_kon, o_restart;
    logic [2:0]  o_op_sel;
    logic [15:0] o_audio_l, o_audio_r;

    fm_voice_seq #(.NUM_OPS(8), .OPS_PER_CH(2), .SAMPLE_DIV(17), .RES_W(13), .OUT_W(16)) u_o (
        .clk(clk), .reset_n(o_rst_n), .kon_wr(1'b0), .kon_wrdata(4'h0),
        .bus_wait(o_bus_wait), .kon(o_kon), .restart(o_restart), .op_sel(o_op_sel),
        .op_next(o_op_next), .op_first(o_op_first), .op_result(13'd100),
        .op_sum(1'b1), .op_pan_l(1'b1), .op_pan_r(1'b0), .op_vol(2'd0),
        .audio_l(o_audio_l), .audio_r(o_audio_r), .audio_valid(o_valid),
        .overrun(o_overrun),
`ifdef FMSEQ_PEAK_EN
        .peak_clr(1'b0), .peak_l(o_peak_l), .peak_r(o_peak_r),
`endif
        .overrun_clr(o_clr));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Step instance A until audio_valid, counting cycles and op_next pulses
    task automatic wait_a_valid(output int cyc, output int nx, output logic fo);
        cyc = 0;
        nx  = 0;
        fo  = 1'b1;
        while (cyc < 200) begin
            step(1);
            cyc++;
            if (a_op_next) begin
                nx++;
                fo = fo & a_op_first;
            end
            if (a_valid) break;
        end
    endtask

    task automatic wait_s_valid(output int cyc);
        cyc = 0;
        while (cyc < 400) begin
            step(1);
            cyc++;
            if (s_valid) break;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, nx, n;
        logic fo;

        a_rst_n = 1'b0; s_rst_n = 1'b0; o_rst_n = 1'b0; o_clr = 1'b0;
        a_kon_wr = 1'b0; a_kon_wrdata = 4'h0;
        a_op_result = 13'd1000; a_op_sum = 1'b1; a_pan_l = 1'b1; a_pan_r = 1'b0; a_vol = 2'd0;
        s_op_result = 13'd4095;
        step(2);

        // ---- reset state ----
        check("rst_audio_l", a_audio_l, 0);
        check("rst_op_first", a_op_first, 1);
        check("rst_op_next", a_op_next, 0);
        check("rst_valid", a_valid, 0);
        check("rst_kon", a_kon, 0);
        check("rst_overrun", a_overrun, 0);

        // ---- first pass: tick at cycle 32, valid 18 cycles later ----
        a_rst_n = 1'b1;
        wait_a_valid(cyc, nx, fo);
        check("first_valid_cycle", cyc, 50);
        check("first_pass_op_next", nx, 8);
        check("first_pass_op_first", fo, 1);
        check("first_audio_l", a_audio_l, 0);
        check("op_first_cleared", a_op_first, 0);

        // ---- 8 x 1000 to left only ----
        wait_a_valid(cyc, nx, fo);
        check("valid_period", cyc, 32);
        check("pass2_op_next", nx, 8);
        check("sum_l_vol0", a_audio_l, 16'd8000);
        check("sum_r_vol0", a_audio_r, 16'd0);

        // ---- op_vol=3: 8 x 125 ----
        a_vol = 2'd3;
        wait_a_valid(cyc, nx, fo);
        check("sum_l_vol3", a_audio_l, 16'd1000);

        // ---- both pans, -1000 >>> 1 = -500, x8 = -4000 ----
        a_vol = 2'd1; a_pan_r = 1'b1; a_op_result = -13'sd1000;
        wait_a_valid(cyc, nx, fo);
        check("sum_l_neg", a_audio_l, 16'hF060);
        check("sum_r_neg", a_audio_r, 16'hF060);

        // ---- key-on write while idle ----
        a_kon_wr = 1'b1; a_kon_wrdata = 4'h5; #1;
        check("bus_wait_idle", a_bus_wait, 0);
        step(1);
        a_kon_wr = 1'b0;
        check("kon_idle_write", a_kon, 4'h5);
        check("restart_set", a_restart, 4'h5);
        wait_a_valid(cyc, nx, fo);
        check("restart_cleared", a_restart, 4'h0);
        check("kon_kept", a_kon, 4'h5);

        // ---- key-on write during a pass (tick 14 cycles after valid) ----
        step(20);
        a_kon_wr = 1'b1; a_kon_wrdata = 4'hA; #1;
        check("bus_wait_busy", a_bus_wait, 1);
        step(1);
        check("kon_held_busy", a_kon, 4'h5);
        n = 0;
        while (a_bus_wait && n < 40) begin
            step(1);
            n++;
        end
        check("bus_wait_cycles", n, 11);
        step(1);
        a_kon_wr = 1'b0;
        check("kon_after_wait", a_kon, 4'hA);
        check("restart_after_wait", a_restart, 4'hA);

        // ---- key-off leaves the pending restart ----
        a_kon_wr = 1'b1; a_kon_wrdata = 4'h0;
        step(1);
        a_kon_wr = 1'b0;
        check("kon_off", a_kon, 4'h0);
        check("restart_survives_keyoff", a_restart, 4'hA);

        // ---- asynchronous reset mid-pass at op_sel=5 ----
        n = 0;
        while (!(a_op_sel == 3'd5 && a_op_next == 1'b0 && a_op_first == 1'b0 && n > 2) && n < 60) begin
            step(1);
            n++;
        end
        check("reach_op_sel5", a_op_sel, 3'd5);
        a_rst_n = 1'b0; #1;
        check("async_op_sel", a_op_sel, 0);
        check("async_op_first", a_op_first, 1);
        check("async_restart", a_restart, 0);
        check("async_audio_l", a_audio_l, 0);
        step(2);
        a_rst_n = 1'b1;
        wait_a_valid(cyc, nx, fo);
        check("restart_first_cycle", cyc, 50);
        check("restart_first_op_first", fo, 1);
        check("restart_first_audio", a_audio_l, 0);
        wait_a_valid(cyc, nx, fo);
        check("restart_second_audio", a_audio_l, 16'hF060);

        // ---- saturation with 64 operators ----
        s_rst_n = 1'b1;
        wait_s_valid(cyc);
        check("s_first_cycle", cyc, 270);
        wait_s_valid(cyc);
        check("sat_pos_l", s_audio_l, 16'h7FFF);
        check("sat_pos_r", s_audio_r, 16'h7FFF);
        s_op_result = 13'h1000;
        wait_s_valid(cyc);
        check("sat_neg_l", s_audio_l, 16'h8000);
        check("sat_neg_r", s_audio_r, 16'h8000);

        // ---- overrun: 17-cycle period puts tick 2 on the last NEXT cycle ----
        o_rst_n = 1'b1;
        step(34);
        check("ovr_before_tick2", o_overrun, 0);
        step(1);
        check("ovr_set_tick2", o_overrun, 1);
        o_clr = 1'b1;
        step(1);
        check("ovr_cleared", o_overrun, 0);
        step(24);
        check("ovr_clear_held_idle", o_overrun, 0);
        step(9);
        check("ovr_set_wins", o_overrun, 1);
        o_clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
